// File: rtl/upsample_nn_if.sv
// Pixel type for the mnist pipeline and the valid/ready feature stream
// interface that carries it between pipeline stages.
package mnist_pkg;
    typedef logic [7:0] feature_type;
endpackage

interface feature_if;
    import mnist_pkg::*;

    logic             valid;
    logic             ready;
    feature_type [0:0] features;

    modport master (output valid, output features, input ready);
    modport slave  (input valid, input features, output ready);
endinterface

// File: rtl/upsample_nn.sv
// Nearest-neighbour upsampler: each input row lands in one of two line banks
// and is replayed ROW_SCALE times with every pixel repeated COL_SCALE times.
module upsample_nn
    import mnist_pkg::*;
#(
    parameter int IN_HEIGHT = 14,
    parameter int IN_WIDTH  = 14,
    parameter int ROW_SCALE = 2,
    parameter int COL_SCALE = 2
) (
    input  logic      clock,
    input  logic      reset_n,
    feature_if.slave  features_in,
    feature_if.master features_out,
    output logic      frame_done
);
    localparam int CW  = (IN_WIDTH  > 1) ? $clog2(IN_WIDTH)  : 1;
    localparam int HW  = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
    localparam int RCW = (COL_SCALE > 1) ? $clog2(COL_SCALE) : 1;
    localparam int RRW = (ROW_SCALE > 1) ? $clog2(ROW_SCALE) : 1;

    localparam logic [CW-1:0]  COL_LAST     = CW'(IN_WIDTH - 1);
    localparam logic [HW-1:0]  ROW_LAST     = HW'(IN_HEIGHT - 1);
    localparam logic [RCW-1:0] REP_COL_LAST = RCW'(COL_SCALE - 1);
    localparam logic [RRW-1:0] REP_ROW_LAST = RRW'(ROW_SCALE - 1);

    feature_type     line_q [2][IN_WIDTH];
    feature_type     line_d [2][IN_WIDTH];
    logic [1:0]      full_q, full_d;
    logic            wr_bank_q, wr_bank_d;
    logic            rd_bank_q, rd_bank_d;
    logic [CW-1:0]   in_col_q, in_col_d;
    logic [CW-1:0]   src_col_q, src_col_d;
    logic [RCW-1:0]  rep_col_q, rep_col_d;
    logic [RRW-1:0]  rep_row_q, rep_row_d;
    logic [HW-1:0]   src_row_q, src_row_d;
    logic            frame_done_q, frame_done_d;

    logic in_fire;
    logic out_fire;
    logic in_last;
    logic rep_col_wrap;
    logic src_col_wrap;
    logic rep_row_wrap;
    logic release_beat;
    logic frame_last;

    // Ready and valid depend only on the bank flags, so neither side sees a
    // combinational path from the other.
    assign features_in.ready        = reset_n & ~full_q[wr_bank_q];
    assign features_out.valid       = full_q[rd_bank_q];
    assign features_out.features[0] = line_q[rd_bank_q][src_col_q];
    assign frame_done               = frame_done_q;

    always_comb begin
        in_fire      = features_in.valid & features_in.ready;
        out_fire     = features_out.valid & features_out.ready;
        in_last      = (in_col_q == COL_LAST);
        rep_col_wrap = (rep_col_q == REP_COL_LAST);
        src_col_wrap = (src_col_q == COL_LAST);
        rep_row_wrap = (rep_row_q == REP_ROW_LAST);
        release_beat = out_fire & rep_col_wrap & src_col_wrap & rep_row_wrap;
        frame_last   = release_beat & (src_row_q == ROW_LAST);

        line_d       = line_q;
        full_d       = full_q;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        in_col_d     = in_col_q;
        src_col_d    = src_col_q;
        rep_col_d    = rep_col_q;
        rep_row_d    = rep_row_q;
        src_row_d    = src_row_q;
        frame_done_d = frame_last;

        if (in_fire) begin
            line_d[wr_bank_q][in_col_q] = features_in.features[0];
            if (in_last) begin
                in_col_d          = '0;
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                in_col_d = in_col_q + CW'(1);
            end
        end

        if (out_fire) begin
            if (rep_col_wrap) begin
                rep_col_d = '0;
                if (src_col_wrap) begin
                    src_col_d = '0;
                    if (rep_row_wrap) begin
                        rep_row_d = '0;
                    end else begin
                        rep_row_d = rep_row_q + RRW'(1);
                    end
                end else begin
                    src_col_d = src_col_q + CW'(1);
                end
            end else begin
                rep_col_d = rep_col_q + RCW'(1);
            end
        end

        // Writer and reader never share a bank, so both flag updates can land
        // in the same cycle without ordering concerns.
        if (release_beat) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            src_row_d         = frame_last ? '0 : src_row_q + HW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            full_q       <= '0;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            in_col_q     <= '0;
            src_col_q    <= '0;
            rep_col_q    <= '0;
            rep_row_q    <= '0;
            src_row_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            full_q       <= full_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            in_col_q     <= in_col_d;
            src_col_q    <= src_col_d;
            rep_col_q    <= rep_col_d;
            rep_row_q    <= rep_row_d;
            src_row_q    <= src_row_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line storage needs no reset: a bank is only read after being fully written.
    always_ff @(posedge clock) begin
        line_q <= line_d;
    end
endmodule

// File: tb/tb_upsample_nn.sv
// Bench for upsample_nn: queue-based reference model for the default 14x14 2x2
// instance plus a directly checked 3x5 (3x1 scale) instance.
module tb_upsample_nn;
    import mnist_pkg::*;

    localparam int W         = 14;
    localparam int H         = 14;
    localparam int RS        = 2;
    localparam int CS        = 2;
    localparam int OUT_W     = W * CS;
    localparam int FRAME_IN  = W * H;
    localparam int FRAME_OUT = FRAME_IN * RS * CS;

    typedef struct {
        int r;
        int c;
        int exp;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic fd_a;
    logic fd_b;

    feature_if ain ();
    feature_if aout ();
    feature_if bin ();
    feature_if bout ();

    upsample_nn dut_a (
        .clock        (clk),
        .reset_n      (rst_n),
        .features_in  (ain),
        .features_out (aout),
        .frame_done   (fd_a)
    );

    upsample_nn #(
        .IN_HEIGHT (3),
        .IN_WIDTH  (5),
        .ROW_SCALE (3),
        .COL_SCALE (1)
    ) dut_b (
        .clock        (clk),
        .reset_n      (rst_n),
        .features_in  (bin),
        .features_out (bout),
        .frame_done   (fd_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // Stimulus controls and model state for instance A
    logic [7:0] src_q [$];
    int         in_pct    = 100;
    int         out_pct   = 100;
    int         out_limit = 1 << 30;

    logic [7:0] row_q [$];
    logic [7:0] exp_q [$];
    logic [7:0] cap [FRAME_OUT];
    logic [7:0] exp_v;
    int         cyc, in_acc, out_cnt, fd_cnt, first_valid, t14;
    bit         in_fire_n, fd_exp;

    always @(posedge clk) begin
        #1;
        if (in_fire_n && src_q.size() > 0) src_q.delete(0);
        if (src_q.size() > 0 && ((ain.valid && !in_fire_n) || $urandom_range(99) < in_pct)) begin
            ain.valid       = 1'b1;
            ain.features[0] = src_q[0];
        end else begin
            ain.valid = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        aout.ready = (out_cnt < out_limit) && ($urandom_range(99) < out_pct);
    end

    // Reference: every completed input row expands into RS copies of the row
    // with each pixel repeated CS times; frame_done follows each FRAME_OUT-th beat.
    always @(negedge clk) begin
        if (!rst_n) begin
            row_q.delete();
            exp_q.delete();
            cyc = 0; in_acc = 0; out_cnt = 0; fd_cnt = 0;
            first_valid = -1; t14 = -1;
            in_fire_n = 1'b0; fd_exp = 1'b0;
        end else begin
            cyc++;
            chk("frame_done", int'(fd_a), int'(fd_exp));
            if (fd_a) fd_cnt++;
            if (aout.valid && first_valid < 0) first_valid = cyc;
            in_fire_n = ain.valid && ain.ready;
            if (in_fire_n) begin
                in_acc++;
                if (in_acc == W) t14 = cyc;
                row_q.push_back(ain.features[0]);
                if (row_q.size() == W) begin
                    for (int rr = 0; rr < RS; rr++)
                        for (int c = 0; c < OUT_W; c++)
                            exp_q.push_back(row_q[c / CS]);
                    row_q.delete();
                end
            end
            fd_exp = 1'b0;
            if (aout.valid && aout.ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_extra got %0d want none", int'(aout.features[0]));
                end else begin
                    exp_v = exp_q.pop_front();
                    if (aout.features[0] !== exp_v) begin
                        errors++;
                        $display("FAIL out_data beat %0d got %0d want %0d", out_cnt,
                                 int'(aout.features[0]), int'(exp_v));
                    end
                end
                if (out_cnt < FRAME_OUT) cap[out_cnt] = aout.features[0];
                out_cnt++;
                fd_exp = (out_cnt % FRAME_OUT == 0);
            end
        end
    end

    // Collector for instance B
    logic [7:0] b_cap [45];
    int         b_cnt, b_fd_cnt, b_fd_at;

    always @(negedge clk) begin
        if (!rst_n) begin
            b_cnt = 0; b_fd_cnt = 0; b_fd_at = -1;
        end else begin
            if (fd_b) begin
                b_fd_cnt++;
                b_fd_at = b_cnt;
            end
            if (bout.valid && bout.ready) begin
                if (b_cnt < 45) b_cap[b_cnt] = bout.features[0];
                b_cnt++;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        src_q.delete();
        @(negedge clk);
        chk("rst_in_ready", int'(ain.ready), 0);
        chk("rst_out_valid", int'(aout.valid), 0);
        chk("rst_frame_done", int'(fd_a), 0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic wait_out(input int n, input int lim);
        int k = 0;
        while (out_cnt < n && k < lim) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
    endtask

    vec_t vt [10];
    logic [7:0] v0;
    int k;

    initial begin
        vt[0] = '{0, 0, 0};
        vt[1] = '{0, 1, 0};
        vt[2] = '{1, 0, 0};
        vt[3] = '{0, 2, 1};
        vt[4] = '{1, 27, 13};
        vt[5] = '{2, 0, 14};
        vt[6] = '{3, 5, 16};
        vt[7] = '{14, 14, 105};
        vt[8] = '{26, 0, 182};
        vt[9] = '{27, 27, 195};

        bin.valid       = 1'b0;
        bin.features[0] = '0;
        bout.ready      = 1'b1;

        // Raster frame, both sides always ready
        do_reset();
        for (int i = 0; i < FRAME_IN; i++) src_q.push_back(8'(i));
        wait_out(FRAME_OUT, 3000);
        chk("t1_beats", out_cnt, FRAME_OUT);
        chk("t1_frame_done_count", fd_cnt, 1);
        chk("t1_first_valid_latency", first_valid, t14 + 1);
        chk("t1_model_drained", exp_q.size(), 0);
        for (int i = 0; i < 10; i++)
            chk($sformatf("t1_pix_r%0d_c%0d", vt[i].r, vt[i].c),
                int'(cap[vt[i].r * OUT_W + vt[i].c]), vt[i].exp);

        // Output held off: two rows fill, then input stalls
        out_limit = 0;
        do_reset();
        for (int i = 0; i < FRAME_IN; i++) src_q.push_back(8'(i));
        repeat (200) @(negedge clk);
        chk("t2_accepted_while_stalled", in_acc, 2 * W);
        chk("t2_in_ready_low", int'(ain.ready), 0);
        chk("t2_no_output", out_cnt, 0);
        out_limit = 1 << 30;
        wait_out(FRAME_OUT, 3000);
        chk("t2_beats", out_cnt, FRAME_OUT);
        chk("t2_frame_done_count", fd_cnt, 1);
        chk("t2_model_drained", exp_q.size(), 0);

        // Random handshakes over three back-to-back frames
        in_pct = 50;
        out_pct = 30;
        do_reset();
        for (int i = 0; i < 3 * FRAME_IN; i++) src_q.push_back(8'($urandom));
        wait_out(3 * FRAME_OUT, 30000);
        chk("t3_beats", out_cnt, 3 * FRAME_OUT);
        chk("t3_frame_done_count", fd_cnt, 3);
        chk("t3_model_drained", exp_q.size(), 0);

        // Stall just before the release beat of bank 0
        in_pct = 100;
        out_pct = 100;
        out_limit = OUT_W * RS - 1;
        do_reset();
        for (int i = 0; i < FRAME_IN; i++) src_q.push_back(8'(i));
        k = 0;
        while ((out_cnt < OUT_W * RS - 1 || ain.ready) && k < 500) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        v0 = aout.features[0];
        chk("t4_stall_value", int'(v0), 13);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_stall_valid", int'(aout.valid), 1);
            chk("t4_stall_data", int'(aout.features[0]), int'(v0));
            chk("t4_stall_in_ready", int'(ain.ready), 0);
        end
        out_limit = OUT_W * RS;
        @(negedge clk);
        chk("t4_release_beat_ready", int'(aout.ready), 1);
        chk("t4_in_ready_before_release", int'(ain.ready), 0);
        @(negedge clk);
        chk("t4_in_ready_after_release", int'(ain.ready), 1);
        out_limit = 1 << 30;
        wait_out(FRAME_OUT, 3000);
        chk("t4_beats", out_cnt, FRAME_OUT);
        chk("t4_frame_done_count", fd_cnt, 1);

        // Reset mid-frame, then a fresh frame
        do_reset();
        for (int i = 0; i < FRAME_IN; i++) src_q.push_back(8'(i) ^ 8'hA5);
        k = 0;
        while (in_acc < 100 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("t5_reached_100", int'(in_acc >= 100), 1);
        do_reset();
        for (int i = 0; i < FRAME_IN; i++) src_q.push_back(8'(i));
        wait_out(FRAME_OUT, 3000);
        chk("t5_beats", out_cnt, FRAME_OUT);
        chk("t5_frame_done_count", fd_cnt, 1);
        chk("t5_first_pixel", int'(cap[0]), 0);
        chk("t5_last_pixel", int'(cap[FRAME_OUT - 1]), 195);

        // Extreme pixel values
        do_reset();
        for (int i = 0; i < FRAME_IN; i++) src_q.push_back((i % 2 == 1) ? 8'hFF : 8'h00);
        wait_out(FRAME_OUT, 3000);
        chk("t6_beats", out_cnt, FRAME_OUT);
        chk("t6_zero", int'(cap[1]), 0);
        chk("t6_ones", int'(cap[2]), 255);
        chk("t6_ones_row1", int'(cap[OUT_W + 3]), 255);

        // 3x5 map with 3x1 scale on instance B
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            bin.valid       = 1'b1;
            bin.features[0] = 8'(i * 17);
            k = 0;
            @(negedge clk);
            while (!bin.ready && k < 100) begin
                @(negedge clk);
                k++;
            end
        end
        @(posedge clk);
        #1;
        bin.valid = 1'b0;
        k = 0;
        while (b_cnt < 45 && k < 500) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        chk("t6b_beats", b_cnt, 45);
        chk("t6b_frame_done_count", b_fd_cnt, 1);
        chk("t6b_frame_done_after_beat", b_fd_at, 45);
        for (int i = 0; i < 45; i++)
            chk($sformatf("t6b_pix_%0d", i), int'(b_cap[i]), ((i / 15) * 5 + (i % 5)) * 17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
